// File: rtl/step_scheduler.sv
// Six-phase commutation stepper: IDLE/RUN/DONE, one step every period+1 clocks, registered drive pattern.
// No backpressure; STEP_BRAKE_EN keeps the last pattern driven in IDLE (brake), otherwise IDLE coasts at 0x00.
module step_scheduler #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          count,
  output logic [2:0]          phase,
  output logic [7:0]          pattern,
  output logic                step_pulse,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [PERIOD_W-1:0]   timer_q, timer_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  step_q, step_d;
  logic [2:0]            next_phase;

  function automatic logic [7:0] drive_tbl(input logic [2:0] ph);
    case (ph)
      3'd0:    drive_tbl = 8'h90;
      3'd1:    drive_tbl = 8'h18;
      3'd2:    drive_tbl = 8'h48;
      3'd3:    drive_tbl = 8'h60;
      3'd4:    drive_tbl = 8'h24;
      3'd5:    drive_tbl = 8'h84;
      default: drive_tbl = 8'h00;
    endcase
  endfunction

  always_comb begin
    if (dir) next_phase = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
    else     next_phase = (phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pattern_d   = pattern_q;
    timer_d     = timer_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    step_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          timer_d     = period;
          period_d    = period;
          remaining_d = count;
          pattern_d   = drive_tbl(phase_q);
        end
      end
      RUN: begin
        // stop outranks a coincident timer expiry: no step on the way out
        if (stop) begin
          state_d = DONE;
        end else if (timer_q == '0) begin
          phase_d   = next_phase;
          pattern_d = drive_tbl(next_phase);
          step_d    = 1'b1;
          timer_d   = period_q;
          // remaining==0 inside RUN only happens for continuous runs
          if (remaining_q != 8'd0) begin
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_d = DONE;
          end
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef STEP_BRAKE_EN
        pattern_d = pattern_q;
`else
        pattern_d = 8'h00;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 3'd0;
      pattern_q   <= 8'h00;
      timer_q     <= '0;
      period_q    <= '0;
      remaining_q <= 8'd0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pattern_q   <= pattern_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
    end
  end

  assign phase      = phase_q;
  assign pattern    = pattern_q;
  assign step_pulse = step_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: table of runs checked through a step scoreboard, plus hand-written corner sequences.
module tb_step_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] count = 8'd0;
  logic [2:0] phase;
  logic [7:0] pattern;
  logic       step_pulse;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int mdl_ph = 0;

`ifdef STEP_BRAKE_EN
  localparam bit BRAKE = 1'b1;
`else
  localparam bit BRAKE = 1'b0;
`endif

  typedef struct {
    int k;
    int ph;
    int pat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit d;
    int p;
    int cnt;
    int mid_k;
    int stop_k;
    int exp_final;
  } vec_t;

  step_scheduler #(.PERIOD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .period(period), .count(count), .phase(phase), .pattern(pattern),
    .step_pulse(step_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int tbl(input int ph);
    case (ph)
      0: return 'h90;
      1: return 'h18;
      2: return 'h48;
      3: return 'h60;
      4: return 'h24;
      5: return 'h84;
      default: return 0;
    endcase
  endfunction

  function automatic int nxt(input int ph, input bit d);
    if (d) return (ph == 5) ? 0 : ph + 1;
    return (ph == 0) ? 5 : ph - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One run: expected steps are queued up front, popped whenever step_pulse is seen.
  task automatic run(input vec_t v);
    int   nsteps, done_k, dones, ph, start_ph;
    exp_t e;
    start_ph = mdl_ph;
    nsteps = (v.cnt != 0) ? v.cnt : (v.stop_k - 1) / (v.p + 1);
    done_k = (v.cnt != 0) ? v.cnt * (v.p + 1) : v.stop_k;
    ph = mdl_ph;
    for (int i = 1; i <= nsteps; i++) begin
      ph = nxt(ph, v.d);
      e.k = i * (v.p + 1);
      e.ph = ph;
      e.pat = tbl(ph);
      sb.push_back(e);
    end
    mdl_ph = ph;
    @(negedge clk);
    start = 1'b1; stop = 1'b0; dir = v.d; period = 8'(v.p); count = 8'(v.cnt);
    dones = 0;
    for (int k = 0; k <= done_k + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop = (k + 1 == v.stop_k);
      if (k + 1 == v.mid_k) begin
        start = 1'b1; period = 8'd0; count = 8'd9;
      end
      if (k == 0) chk("load_pattern", pattern, tbl(start_ph));
      chk("busy", busy, k <= done_k);
      if (step_pulse) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_step: step_pulse at cycle %0d, required none", k);
        end else begin
          e = sb.pop_front();
          chk("step_cycle", k, e.k);
          chk("step_phase", phase, e.ph);
          chk("step_pattern", pattern, e.pat);
        end
      end
      if (done) begin
        dones++;
        chk("done_cycle", k, done_k);
      end
    end
    stop = 1'b0;
    chk("steps_missing", sb.size(), 0);
    sb.delete();
    chk("done_count", dones, 1);
    chk("final_phase", phase, v.exp_final);
    chk("idle_pattern", pattern, BRAKE ? tbl(v.exp_final) : 0);
  endtask

  vec_t vecs[6];
  vec_t v;
  int   dones;

  initial begin
    vecs[0] = '{1'b1, 2, 3, -1, -1, 3};  // 0 -> 1,2,3 at cycles 3,6,9
    vecs[1] = '{1'b1, 1, 3, -1, -1, 0};  // forward wrap 5 -> 0
    vecs[2] = '{1'b0, 0, 2, -1, -1, 4};  // reverse wrap 0 -> 5, step every clock
    vecs[3] = '{1'b0, 3, 1, -1, -1, 3};  // single step ending at phase 3
    vecs[4] = '{1'b1, 0, 6, -1, -1, 3};  // full revolution
    vecs[5] = '{1'b1, 1, 2, 3, -1, 5};   // start mid-run with count=9 is ignored

    #12;
    chk("rst_phase", phase, 0);
    chk("rst_pattern", pattern, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // start together with stop in IDLE stays idle
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    @(negedge clk);
    chk("startstop_busy2", busy, 0);
    chk("startstop_phase", phase, mdl_ph);

    // continuous reverse run from 5, reset asserted once it reaches phase 3
    @(negedge clk);
    start = 1'b1; dir = 1'b0; period = 8'd1; count = 8'd0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_phase", phase, 3);
    chk("pre_rst_pattern", pattern, 'h60);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_pattern", pattern, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    mdl_ph = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dones++;
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_done", dones, 0);
    chk("post_rst_pattern", pattern, 0);

    // continuous forward from 0 for 8 steps, stop coincides with timer expiry
    v = '{1'b1, 0, 0, -1, 9, 2};
    run(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
